// File: rtl/enc8b10b_pkg.sv
// rtl/enc8b10b_pkg.sv - shared 8b/10b types, control symbols and sub-block decode tables
// Purpose: running-disparity type, K-symbol constants and the 6b/4b sub-block
//          decode functions used by the line decoder (and shared with the encoder).
// Contents:
//   rd_t    running disparity (RD_NEG = -1, RD_POS = +1)
//   disp_t  sub-block disparity class (0, +2, -2, |d|>=4)
//   dec6b   abcdei -> {valid, EDCBA, disp}
//   dec4b   fghj   -> {valid, HGF, disp}
package enc8b10b_pkg;

  typedef enum logic {RD_NEG = 1'b0, RD_POS = 1'b1} rd_t;

  typedef enum logic [1:0] {
    DISP_ZERO = 2'd0,
    DISP_POS  = 2'd1,
    DISP_NEG  = 2'd2,
    DISP_BAD  = 2'd3
  } disp_t;

  localparam logic [8:0] K28_5 = 9'h1BC;
  localparam logic [8:0] K28_1 = 9'h13C;
  localparam logic [8:0] K28_7 = 9'h1FC;

  typedef struct packed {
    logic       valid;
    logic [4:0] data;
    disp_t      disp;
  } dec6_t;

  typedef struct packed {
    logic       valid;
    logic [2:0] data;
    disp_t      disp;
  } dec4_t;

  function automatic disp_t disp6(input logic [5:0] b);
    case ($countones(b))
      3:       return DISP_ZERO;
      4:       return DISP_POS;
      2:       return DISP_NEG;
      default: return DISP_BAD;
    endcase
  endfunction

  function automatic disp_t disp4(input logic [3:0] b);
    case ($countones(b))
      2:       return DISP_ZERO;
      3:       return DISP_POS;
      1:       return DISP_NEG;
      default: return DISP_BAD;
    endcase
  endfunction

  // Both polarities of every 5b/6b code; 001111/110000 are the K28 forms.
  function automatic dec6_t dec6b(input logic [5:0] abcdei);
    dec6_t r;
    r.valid = 1'b1;
    r.data  = 5'd0;
    r.disp  = disp6(abcdei);
    case (abcdei)
      6'b100111, 6'b011000: r.data = 5'd0;
      6'b011101, 6'b100010: r.data = 5'd1;
      6'b101101, 6'b010010: r.data = 5'd2;
      6'b110001:            r.data = 5'd3;
      6'b110101, 6'b001010: r.data = 5'd4;
      6'b101001:            r.data = 5'd5;
      6'b011001:            r.data = 5'd6;
      6'b111000, 6'b000111: r.data = 5'd7;
      6'b111001, 6'b000110: r.data = 5'd8;
      6'b100101:            r.data = 5'd9;
      6'b010101:            r.data = 5'd10;
      6'b110100:            r.data = 5'd11;
      6'b001101:            r.data = 5'd12;
      6'b101100:            r.data = 5'd13;
      6'b011100:            r.data = 5'd14;
      6'b010111, 6'b101000: r.data = 5'd15;
      6'b011011, 6'b100100: r.data = 5'd16;
      6'b100011:            r.data = 5'd17;
      6'b010011:            r.data = 5'd18;
      6'b110010:            r.data = 5'd19;
      6'b001011:            r.data = 5'd20;
      6'b101010:            r.data = 5'd21;
      6'b011010:            r.data = 5'd22;
      6'b111010, 6'b000101: r.data = 5'd23;
      6'b110011, 6'b001100: r.data = 5'd24;
      6'b100110:            r.data = 5'd25;
      6'b010110:            r.data = 5'd26;
      6'b110110, 6'b001001: r.data = 5'd27;
      6'b001110:            r.data = 5'd28;
      6'b001111, 6'b110000: r.data = 5'd28;
      6'b101110, 6'b010001: r.data = 5'd29;
      6'b011110, 6'b100001: r.data = 5'd30;
      6'b101011, 6'b010100: r.data = 5'd31;
      default:              r.valid = 1'b0;
    endcase
    return r;
  endfunction

  // 1110/0001 is the primary .7, 0111/1000 the alternate .7.
  function automatic dec4_t dec4b(input logic [3:0] fghj);
    dec4_t r;
    r.valid = 1'b1;
    r.data  = 3'd0;
    r.disp  = disp4(fghj);
    case (fghj)
      4'b1011, 4'b0100: r.data = 3'd0;
      4'b1001:          r.data = 3'd1;
      4'b0101:          r.data = 3'd2;
      4'b1100, 4'b0011: r.data = 3'd3;
      4'b1101, 4'b0010: r.data = 3'd4;
      4'b1010:          r.data = 3'd5;
      4'b0110:          r.data = 3'd6;
      4'b1110, 4'b0001: r.data = 3'd7;
      4'b0111, 4'b1000: r.data = 3'd7;
      default:          r.valid = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/decoder_10b8b_lut.sv
// rtl/decoder_10b8b_lut.sv - combinational 10b symbol decode with RD and error checks
// Purpose: decodes one 10-bit symbol against an incoming running disparity.
// Ports:
//   symbol    in  10  [9:4]=abcdei (a=bit9), [3:0]=fghj (f=bit3)
//   rd_in     in  rd_t running disparity before the symbol
//   data9     out 9   {K, HGFEDCBA}; zero on code_err
//   code_err  out 1   symbol not a legal data or control code
//   disp_err  out 1   sub-block disparity illegal for the current RD (never with code_err)
//   rd_out    out rd_t running disparity after the symbol
module decoder_10b8b_lut
  import enc8b10b_pkg::*;
(
  input  logic [9:0] symbol,
  input  rd_t        rd_in,
  output logic [8:0] data9,
  output logic       code_err,
  output logic       disp_err,
  output rd_t        rd_out
);

  logic [5:0] six;
  logic [3:0] four;
  logic       k28_pos;
  dec6_t      r6;
  dec4_t      r4;
  disp_t      d4;
  rd_t        rd_mid;
  logic       de6, de4;
  logic       is_k28, is_a7, is_p7, is_kx7, a7_ok;

  assign six  = symbol[9:4];
  assign four = symbol[3:0];

  // K28 sent from RD+ is the bitwise complement of the RD- form, so its
  // 4b part is decoded after complementing; disparity is swapped back below.
  assign k28_pos = (six == 6'b110000);
  assign r6      = dec6b(six);
  assign r4      = dec4b(k28_pos ? ~four : four);

  assign is_k28 = (six == 6'b001111) || k28_pos;
  assign is_a7  = (four == 4'b0111) || (four == 4'b1000);
  assign is_p7  = (four == 4'b1110) || (four == 4'b0001);
  assign is_kx7 = is_a7 && !is_k28 && (r6.data inside {5'd23, 5'd27, 5'd29, 5'd30});

  always_comb begin
    rd_mid = rd_in;
    de6    = 1'b0;
    case (r6.disp)
      DISP_ZERO: de6 = ((six == 6'b000111) && (rd_in != RD_POS)) ||
                       ((six == 6'b111000) && (rd_in != RD_NEG));
      DISP_POS: begin
        de6    = (rd_in == RD_POS);
        rd_mid = RD_POS;
      end
      DISP_NEG: begin
        de6    = (rd_in == RD_NEG);
        rd_mid = RD_NEG;
      end
      default: ;
    endcase
    // 111100/000011 have |d|=2 but are not codes; they leave RD alone.
    if (!r6.valid) begin
      rd_mid = rd_in;
      de6    = 1'b0;
    end
  end

  always_comb begin
    d4 = r4.disp;
    if (k28_pos && (r4.disp == DISP_POS)) d4 = DISP_NEG;
    if (k28_pos && (r4.disp == DISP_NEG)) d4 = DISP_POS;
  end

  always_comb begin
    rd_out = rd_mid;
    de4    = 1'b0;
    case (d4)
      DISP_ZERO: de4 = ((four == 4'b0011) && (rd_mid != RD_POS)) ||
                       ((four == 4'b1100) && (rd_mid != RD_NEG));
      DISP_POS: begin
        de4    = (rd_mid == RD_POS);
        rd_out = RD_POS;
      end
      DISP_NEG: begin
        de4    = (rd_mid == RD_NEG);
        rd_out = RD_NEG;
      end
      default: ;
    endcase
  end

  // The alternate .7 only appears where the primary would produce a run of five.
  assign a7_ok = ((r6.data inside {5'd17, 5'd18, 5'd20}) && (rd_mid == RD_NEG)) ||
                 ((r6.data inside {5'd11, 5'd13, 5'd14}) && (rd_mid == RD_POS));

  always_comb begin
    code_err = !r6.valid || !r4.valid ||
               (is_k28 && is_p7) ||
               (is_a7 && !is_k28 && !is_kx7 && !a7_ok);
    data9    = code_err ? 9'h000 : {is_k28 || is_kx7, r4.data, r6.data};
    disp_err = !code_err && (de6 || de4);
  end

endmodule

// File: rtl/decoder_10b8b.sv
// rtl/decoder_10b8b.sv - registered 10b/8b line decoder with running disparity tracking
// Purpose: receive-side 8b/10b decoder, one symbol per push, one cycle latency.
// Parameters:
//   CHECK_DISP  1: report disparity errors; 0: disp_err tied low (RD still tracked)
// Ports:
//   clk       in  1   rising-edge clock
//   reset     in  1   synchronous, active-high
//   pushin    in  1   datain/startin valid
//   datain    in  10  symbol, abcdei in [9:4], fghj in [3:0]
//   startin   in  1   first symbol of a frame; restarts RD at -1
//   pushout   out 1   outputs below valid
//   dataout   out 9   {K, HGFEDCBA}
//   startout  out 1   startin delayed with its symbol
//   code_err  out 1   illegal symbol
//   disp_err  out 1   disparity violation
module decoder_10b8b
  import enc8b10b_pkg::*;
#(
  parameter bit CHECK_DISP = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       pushin,
  input  logic [9:0] datain,
  input  logic       startin,
  output logic       pushout,
  output logic [8:0] dataout,
  output logic       startout,
  output logic       code_err,
  output logic       disp_err
);

  rd_t        rd_q;
  rd_t        rd_in;
  rd_t        rd_next;
  logic [8:0] lut_data;
  logic       lut_code_err;
  logic       lut_disp_err;

  // A frame start decodes from RD=-1 regardless of history.
  assign rd_in = (pushin && startin) ? RD_NEG : rd_q;

  decoder_10b8b_lut u_lut (
    .symbol   (datain),
    .rd_in    (rd_in),
    .data9    (lut_data),
    .code_err (lut_code_err),
    .disp_err (lut_disp_err),
    .rd_out   (rd_next)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      pushout  <= 1'b0;
      dataout  <= 9'h000;
      startout <= 1'b0;
      code_err <= 1'b0;
      disp_err <= 1'b0;
      rd_q     <= RD_NEG;
    end else begin
      pushout <= pushin;
      if (pushin) begin
        dataout  <= lut_data;
        startout <= startin;
        code_err <= lut_code_err;
        disp_err <= CHECK_DISP ? lut_disp_err : 1'b0;
        rd_q     <= rd_next;
      end
    end
  end

endmodule
